memory_stage: RTL

//  Y-86 pipeline memory stage, downstream of execute. Holds the M pipeline register (E->M) and the

---
 rtl/y86_pkg.sv | 52 +++++
 rtl/memory_stage_if.sv | 37 +++
 rtl/memory_stage_data_mem.sv | 56 +++++
 rtl/memory_stage.sv | 85 ++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y-86 constants and the M pipeline register payload for the memory stage.
package y86_pkg;

    localparam int unsigned WORD_W  = 64;
    localparam int unsigned ICODE_W = 4;
    localparam int unsigned STAT_W  = 4;
    localparam int unsigned REG_W   = 4;

    localparam logic [ICODE_W-1:0] I_HALT   = 4'h0;
    localparam logic [ICODE_W-1:0] I_NOP    = 4'h1;
    localparam logic [ICODE_W-1:0] I_RRMOVQ = 4'h2;
    localparam logic [ICODE_W-1:0] I_IRMOVQ = 4'h3;
    localparam logic [ICODE_W-1:0] I_RMMOVQ = 4'h4;
    localparam logic [ICODE_W-1:0] I_MRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] I_OPQ    = 4'h6;
    localparam logic [ICODE_W-1:0] I_JXX    = 4'h7;
    localparam logic [ICODE_W-1:0] I_CALL   = 4'h8;
    localparam logic [ICODE_W-1:0] I_RET    = 4'h9;
    localparam logic [ICODE_W-1:0] I_PUSHQ  = 4'hA;
    localparam logic [ICODE_W-1:0] I_POPQ   = 4'hB;

    localparam logic [STAT_W-1:0] S_AOK = 4'b1000;
    localparam logic [STAT_W-1:0] S_HLT = 4'b0100;
    localparam logic [STAT_W-1:0] S_ADR = 4'b0010;
    localparam logic [STAT_W-1:0] S_INS = 4'b0001;

    localparam logic [REG_W-1:0] RNONE = 4'hF;

    typedef struct packed {
        logic [STAT_W-1:0]  stat;
        logic [ICODE_W-1:0] icode;
        logic               cnd;
        logic [WORD_W-1:0]  val_e;
        logic [WORD_W-1:0]  val_a;
        logic [REG_W-1:0]   dst_e;
        logic [REG_W-1:0]   dst_m;
    } m_reg_t;

    function automatic logic is_mem_read(input logic [ICODE_W-1:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ) || (icode == I_RET);
    endfunction

    function automatic logic is_mem_write(input logic [ICODE_W-1:0] icode);
        return (icode == I_RMMOVQ) || (icode == I_PUSHQ) || (icode == I_CALL);
    endfunction

    // Stack reads (pop/ret) address through valA; everything else through valE.
    function automatic logic addr_from_val_a(input logic [ICODE_W-1:0] icode);
        return (icode == I_POPQ) || (icode == I_RET);
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Execute-to-memory handshake bundle: pipeline control, E-stage values in, M-stage values out.
interface memory_stage_if;
    import y86_pkg::*;

    logic                M_stall;
    logic                M_bubble;
    logic [STAT_W-1:0]   W_stat;
    logic [STAT_W-1:0]   e_stat;
    logic [ICODE_W-1:0]  e_icode;
    logic                e_Cnd;
    logic [WORD_W-1:0]   e_valE;
    logic [WORD_W-1:0]   e_valA;
    logic [REG_W-1:0]    e_dstE;
    logic [REG_W-1:0]    e_dstM;

    logic [ICODE_W-1:0]  M_icode;
    logic                M_Cnd;
    logic [WORD_W-1:0]   M_valE;
    logic [WORD_W-1:0]   M_valA;
    logic [REG_W-1:0]    M_dstE;
    logic [REG_W-1:0]    M_dstM;
    logic [STAT_W-1:0]   m_stat;
    logic [WORD_W-1:0]   m_valM;

    modport master (
        output M_stall, M_bubble, W_stat,
        output e_stat, e_icode, e_Cnd, e_valE, e_valA, e_dstE, e_dstM,
        input  M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, m_stat, m_valM
    );

    modport slave (
        input  M_stall, M_bubble, W_stat,
        input  e_stat, e_icode, e_Cnd, e_valE, e_valA, e_dstE, e_dstM,
        output M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, m_stat, m_valM
    );

endinterface

// File: rtl/memory_stage_data_mem.sv
// Byte-addressable data memory: async 8-byte little-endian read, sync 8-byte write.
// MEM_ALIGN_CHK_EN adds a misaligned-address error on top of the range check.
module data_mem
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              i_access,
    input  logic              i_we,
    input  logic [WORD_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata,
    output logic              o_err
);

    localparam int unsigned AW       = $clog2(MEM_BYTES);
    localparam int unsigned N_BYTES  = WORD_W / 8;
    localparam logic [WORD_W-1:0] ADDR_MAX = WORD_W'(MEM_BYTES - N_BYTES);

    logic [7:0]    r_mem [MEM_BYTES];
    logic [AW-1:0] w_base;
    logic          w_range_err;
    logic          w_align_err;

    assign w_base      = i_addr[AW-1:0];
    assign w_range_err = (i_addr > ADDR_MAX);

`ifdef MEM_ALIGN_CHK_EN
    assign w_align_err = (i_addr[2:0] != 3'b000);
`else
    assign w_align_err = 1'b0;
`endif

    assign o_err = i_access & (w_range_err | w_align_err);

    // Byte at the base address lands in the least significant byte lane.
    always_comb begin
        o_rdata = '0;
        if (!o_err) begin
            for (int k = 0; k < int'(N_BYTES); k++) begin
                o_rdata[8*k +: 8] = r_mem[w_base + AW'(k)];
            end
        end
    end

    // Contents are intentionally left out of reset so data survives a pipeline restart.
    always_ff @(posedge clk) begin
        if (i_we && !o_err) begin
            for (int k = 0; k < int'(N_BYTES); k++) begin
                r_mem[w_base + AW'(k)] <= i_wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Y-86 memory stage: M pipeline register, load/store decode and data memory access.
// Build option MEM_ALIGN_CHK_EN (in data_mem) turns misaligned accesses into ADR faults.
module memory_stage
    import y86_pkg::*;
#(
    parameter int unsigned        MEM_BYTES = 1024,
    parameter logic [ICODE_W-1:0] RST_ICODE = 4'h1
) (
    input  logic           clk,
    input  logic           rst,
    memory_stage_if.slave  bus
);

    localparam m_reg_t M_RST = '{
        stat:  S_AOK,
        icode: RST_ICODE,
        cnd:   1'b0,
        val_e: '0,
        val_a: '0,
        dst_e: RNONE,
        dst_m: RNONE
    };

    m_reg_t            r_m;
    m_reg_t            w_e;
    logic              w_rd;
    logic              w_wr;
    logic              w_access;
    logic              w_we;
    logic              w_err;
    logic [WORD_W-1:0] w_addr;
    logic [WORD_W-1:0] w_rdata;

    assign w_e = '{
        stat:  bus.e_stat,
        icode: bus.e_icode,
        cnd:   bus.e_Cnd,
        val_e: bus.e_valE,
        val_a: bus.e_valA,
        dst_e: bus.e_dstE,
        dst_m: bus.e_dstM
    };

    // M register: reset beats bubble beats stall beats load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m <= M_RST;
        end else if (bus.M_bubble) begin
            r_m <= M_RST;
        end else if (!bus.M_stall) begin
            r_m <= w_e;
        end
    end

    assign w_rd     = is_mem_read(r_m.icode);
    assign w_wr     = is_mem_write(r_m.icode);
    assign w_access = w_rd | w_wr;
    assign w_addr   = addr_from_val_a(r_m.icode) ? r_m.val_a : r_m.val_e;

    // A faulting instruction in writeback must not let a younger store update memory.
    assign w_we = w_wr & ~w_err & (bus.W_stat == S_AOK) & ~rst;

    data_mem #(
        .MEM_BYTES (MEM_BYTES)
    ) u_mem (
        .clk      (clk),
        .i_access (w_access),
        .i_we     (w_we),
        .i_addr   (w_addr),
        .i_wdata  (r_m.val_a),
        .o_rdata  (w_rdata),
        .o_err    (w_err)
    );

    assign bus.m_stat  = w_err ? S_ADR : r_m.stat;
    assign bus.m_valM  = (w_rd && !w_err) ? w_rdata : '0;

    assign bus.M_icode = r_m.icode;
    assign bus.M_Cnd   = r_m.cnd;
    assign bus.M_valE  = r_m.val_e;
    assign bus.M_valA  = r_m.val_a;
    assign bus.M_dstE  = r_m.dst_e;
    assign bus.M_dstM  = r_m.dst_m;

endmodule
